// File: rtl/defuzz_seq.sv
// Multi-cycle centroid defuzzifier: G = round(S_wg*SCALE / max(S_w,EPS)), saturated to SCALE.
// A radix-2 restoring divider produces one quotient bit per cycle.
module defuzz_seq #(
  parameter int W     = 16,
  parameter int OUT_W = 8,
  parameter int SCALE = 100,
  parameter int EPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     s_w,
  input  logic [W-1:0]     s_wg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] g_out,
  output logic             eps_used
);

  localparam int NUM_W = W + $clog2(SCALE + 1) + 1;
  localparam int CNT_W = $clog2(NUM_W);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready depends only on state; out_valid is a register; neither looks at its partner.
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nxt;
  logic [W-1:0]         den;
  logic [NUM_W-1:0]     num;
  logic [NUM_W-2:0]     quo;
  logic [NUM_W-1:0]     rem;
  logic [CNT_W-1:0]     step;

  logic                 accept;
  logic                 last_step;
  logic                 qbit;
  logic [W-1:0]         d_in;
  logic [NUM_W-1:0]     n_in;
  logic [NUM_W:0]       trial;
  logic [NUM_W:0]       den2;
  logic [NUM_W-1:0]     rem_nxt;
  logic [NUM_W-1:0]     q_final;
  logic [OUT_W-1:0]     g_sat;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_step = (step == CNT_W'(NUM_W - 1));

  // Adding D before dividing by 2D turns truncation into round-half-up.
  always_comb begin
    d_in = (s_w < W'(EPS)) ? W'(EPS) : s_w;
    n_in = NUM_W'(2) * NUM_W'(SCALE) * NUM_W'(s_wg) + NUM_W'(d_in);
  end

  always_comb begin
    den2    = (NUM_W + 1)'({den, 1'b0});
    trial   = {rem, num[NUM_W-1]};
    qbit    = (trial >= den2);
    rem_nxt = qbit ? NUM_W'(trial - den2) : trial[NUM_W-1:0];
    q_final = {quo, qbit};
    g_sat   = (q_final > NUM_W'(SCALE)) ? OUT_W'(SCALE) : q_final[OUT_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      den       <= '0;
      num       <= '0;
      quo       <= '0;
      rem       <= '0;
      step      <= '0;
      g_out     <= '0;
      eps_used  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            den      <= d_in;
            num      <= n_in;
            rem      <= '0;
            quo      <= '0;
            step     <= '0;
            eps_used <= (s_w < W'(EPS));
          end
        end
        BUSY: begin
          num  <= num << 1;
          rem  <= rem_nxt;
          quo  <= q_final[NUM_W-2:0];
          step <= step + CNT_W'(1);
          // The final quotient bit is folded straight into the saturated result.
          if (last_step) begin
            g_out     <= g_sat;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_defuzz_seq.sv
// Self-checking bench for defuzz_seq: directed cases on a default instance plus
// concurrent randomized sweeps on a default and a W=12/SCALE=255 instance.
module tb_defuzz_seq;

  localparam int DEF_LAT  = 25;
  localparam int N_PAIRS  = 1200;

  logic clk;
  logic rst_n;
  logic sweep_rst_n;
  int   n_tests;
  int   n_fail;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: round-half-up of swg*scale/max(sw,eps), saturated to scale.
  function automatic longint model_g(input longint sw, input longint swg,
                                     input longint scale, input longint eps);
    longint d, q;
    d = (sw < eps) ? eps : sw;
    q = (2 * swg * scale + d) / (2 * d);
    if (q > scale) q = scale;
    return q;
  endfunction

  // ---------------- directed instance ----------------
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_eps_used;
  logic [15:0] d_s_w, d_s_wg;
  logic [7:0]  d_g_out;

  defuzz_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .s_w(d_s_w), .s_wg(d_s_wg),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .g_out(d_g_out), .eps_used(d_eps_used)
  );

  task automatic do_pair(input logic [15:0] sw, input logic [15:0] swg,
                         input int eg, input bit ee, input string nm);
    int edges;
    @(negedge clk);
    check({nm, " in_ready"}, 64'(d_in_ready), 64'd1);
    d_in_valid = 1'b1; d_s_w = sw; d_s_wg = swg; d_out_ready = 1'b1;
    @(posedge clk);
    edges = 1;
    #1 d_in_valid = 1'b0;
    while (!d_out_valid && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
    end
    check({nm, " latency"}, 64'(edges), 64'(DEF_LAT));
    check({nm, " g_out"}, 64'(d_g_out), 64'(eg));
    check({nm, " eps_used"}, 64'(d_eps_used), 64'(ee));
    @(posedge clk);
    #1;
    check({nm, " out_valid cleared"}, 64'(d_out_valid), 64'd0);
    check({nm, " in_ready after"}, 64'(d_in_ready), 64'd1);
  endtask

  task automatic backpressure_test();
    int  guard;
    bit  spurious;
    @(negedge clk);
    d_out_ready = 1'b0; d_in_valid = 1'b1; d_s_w = 16'd10; d_s_wg = 16'd7;
    @(posedge clk);
    #1 d_in_valid = 1'b0;
    guard = 0;
    while (!d_out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("bp result arrives", 64'(d_out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp out_valid held", 64'(d_out_valid), 64'd1);
      check("bp g_out held", 64'(d_g_out), 64'd70);
      check("bp in_ready low", 64'(d_in_ready), 64'd0);
      if (i == 3) begin d_in_valid = 1'b1; d_s_w = 16'd1; d_s_wg = 16'd1; end
      if (i == 6) d_in_valid = 1'b0;
    end
    d_out_ready = 1'b1;
    @(negedge clk);
    check("bp released out_valid", 64'(d_out_valid), 64'd0);
    check("bp released in_ready", 64'(d_in_ready), 64'd1);
    spurious = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (d_out_valid) spurious = 1'b1;
    end
    check("bp ignored pulse", 64'(spurious), 64'd0);
  endtask

  task automatic reset_mid_busy_test();
    @(negedge clk);
    d_out_ready = 1'b1; d_in_valid = 1'b1; d_s_w = 16'd9; d_s_wg = 16'd9;
    @(posedge clk);
    #1 d_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst busy out_valid", 64'(d_out_valid), 64'd0);
    check("rst busy g_out", 64'(d_g_out), 64'd0);
    check("rst busy eps_used", 64'(d_eps_used), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst busy in_ready", 64'(d_in_ready), 64'd1);
    do_pair(16'd4, 16'd1, 25, 1'b0, "after reset 4/1");
  endtask

  // ---------------- randomized sweeps ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int SW   = (gi == 0) ? 16 : 12;
    localparam int SSC  = (gi == 0) ? 100 : 255;
    localparam int SNUM = SW + $clog2(SSC + 1) + 1;

    logic          in_valid, in_ready, out_valid, out_ready, eps_used;
    logic [SW-1:0] s_w, s_wg;
    logic [7:0]    g_out;
    logic [8:0]    exp_q[$];
    int            cyc, acc_cyc, n_acc, n_out;
    bit            done;

    defuzz_seq #(.W(SW), .OUT_W(8), .SCALE(SSC), .EPS(1)) dut_s (
      .clk(clk), .rst_n(sweep_rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .s_w(s_w), .s_wg(s_wg),
      .out_valid(out_valid), .out_ready(out_ready),
      .g_out(g_out), .eps_used(eps_used)
    );

    initial begin
      bit   pend;
      logic [8:0] e;
      in_valid = 1'b0; out_ready = 1'b0; s_w = '0; s_wg = '0;
      done = 1'b0; cyc = 0; acc_cyc = 0; n_acc = 0; n_out = 0;
      wait (sweep_rst_n === 1'b1);
      while ((n_acc < N_PAIRS || exp_q.size() != 0) && cyc < 80000) begin
        @(negedge clk);
        cyc++;
        pend = (exp_q.size() != 0);
        check($sformatf("sweep%0d in_ready", gi), 64'(in_ready), 64'(!pend));
        check($sformatf("sweep%0d out_valid timing", gi), 64'(out_valid),
              64'(pend && (cyc - acc_cyc >= SNUM + 1)));
        if (out_valid && pend)
          check($sformatf("sweep%0d result", gi), 64'({eps_used, g_out}), 64'(exp_q[0]));
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid  = ($urandom_range(0, 1) == 1) && (n_acc < N_PAIRS);
        case ($urandom_range(0, 5))
          0: begin
            s_w  = SW'($urandom_range(0, 3));
            s_wg = SW'($urandom_range(0, 7));
          end
          1: begin
            s_w  = SW'($urandom_range(0, (1 << SW) - 1));
            s_wg = s_w >> $urandom_range(0, 8);
          end
          default: begin
            s_w  = SW'($urandom_range(0, (1 << SW) - 1));
            s_wg = SW'($urandom_range(0, (1 << SW) - 1));
          end
        endcase
        if (out_valid && out_ready && pend) begin
          void'(exp_q.pop_front());
          n_out++;
        end
        if (in_valid && in_ready) begin
          e = {s_w < 1, 8'(model_g(longint'(s_w), longint'(s_wg), SSC, 1))};
          exp_q.push_back(e);
          acc_cyc = cyc;
          n_acc++;
        end
      end
      check($sformatf("sweep%0d results delivered", gi), 64'(n_out), 64'(N_PAIRS));
      done = 1'b1;
    end
  end

  // ---------------- main sequence / final report ----------------
  initial begin
    int guard;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; sweep_rst_n = 1'b0;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_s_w = '0; d_s_wg = '0;

    check("model 8000/4000", 64'(model_g(32768, 16384, 100, 1)), 64'd50);
    check("model 3/1", 64'(model_g(3, 1, 100, 1)), 64'd33);
    check("model 200/1 half", 64'(model_g(200, 1, 100, 1)), 64'd1);
    check("model 0/5 sat", 64'(model_g(0, 5, 100, 1)), 64'd100);
    check("model 12b 4/1", 64'(model_g(4, 1, 255, 1)), 64'd64);

    repeat (3) @(negedge clk);
    rst_n = 1'b1; sweep_rst_n = 1'b1;
    #1;
    check("reset out_valid", 64'(d_out_valid), 64'd0);
    check("reset g_out", 64'(d_g_out), 64'd0);
    check("reset eps_used", 64'(d_eps_used), 64'd0);
    check("reset in_ready", 64'(d_in_ready), 64'd1);

    do_pair(16'h8000, 16'h4000, 50, 1'b0, "half scale");
    do_pair(16'd3, 16'd1, 33, 1'b0, "round 1/3");
    do_pair(16'd3, 16'd2, 67, 1'b0, "round 2/3");
    do_pair(16'd200, 16'd1, 1, 1'b0, "half rounds up");
    do_pair(16'd201, 16'd1, 0, 1'b0, "below half");
    do_pair(16'd0, 16'd0, 0, 1'b1, "eps zero");
    do_pair(16'd0, 16'd5, 100, 1'b1, "eps saturate");
    do_pair(16'h1000, 16'hFFFF, 100, 1'b0, "saturate");
    backpressure_test();
    reset_mid_busy_test();

    guard = 0;
    while (!(g_sweep[0].done && g_sweep[1].done) && guard < 90000) begin
      @(negedge clk);
      guard++;
    end
    check("sweeps finished", 64'(g_sweep[0].done && g_sweep[1].done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
